// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target block.
//   i2c_target_state_t       - protocol state of the target FSM
//   I2C_DEFAULT_TARGET_ADDR  - 7-bit address answered by default (7'h4B)
//   DATA_W / BYTE_W          - width of the served word and of one bus byte
//   select_byte()            - picks the high or low byte of the served word
package i2c_pkg;

  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;
  localparam logic [6:0] I2C_DEFAULT_TARGET_ADDR = 7'h4B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RD_BYTE,
    S_RD_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_WAIT_STOP
  } i2c_target_state_t;

  function automatic logic [BYTE_W-1:0] select_byte(input logic [DATA_W-1:0] word,
                                                     input logic            high);
    return high ? word[DATA_W-1:BYTE_W] : word[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings one open-drain bus line into the clk domain.
// Two-flop synchronizer, optional 3-sample agreement filter, and single-clk
// rise/fall strobes taken on the synchronized (and filtered) level.
// Configuration macro: I2C_TARGET_GLITCH_FILTER_EN adds the agreement filter,
// which rejects pulses of 2 clk or less at the cost of 2 extra clk latency.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset (line assumed idle-high)
//   line_in  in   raw bus line
//   line     out  synchronized level
//   rise     out  one-clk strobe on a 0->1 transition of line
//   fall     out  one-clk strobe on a 1->0 transition of line
module i2c_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic line,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       line_prev;

  // Bus idles high, so the flops reset to 1 to avoid a false edge at start-up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], line_in};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       held;

  // The window is the two older samples plus the current synchronized one, so
  // the output moves on the third equal sample: +2 clk over the plain path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= 2'b11;
      held <= 1'b1;
    end else begin
      hist <= {hist[0], sync[1]};
      held <= line;
    end
  end

  always_comb begin
    line = held;
    if ((hist[1] == sync[1]) && (hist[0] == sync[1])) begin
      line = sync[1];
    end
  end
`else
  assign line = sync[1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_prev <= 1'b1;
    end else begin
      line_prev <= line;
    end
  end

  assign rise = line & ~line_prev;
  assign fall = ~line & line_prev;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C responder. Reads return a 16-bit snapshot of data_in as two
// bytes MSB first (wrapping on further ACKs); writes are acknowledged byte by
// byte and presented on wr_data/wr_valid. The clock is never stretched.
// Configuration macro: I2C_TARGET_GLITCH_FILTER_EN (see i2c_line_sync).
// Parameters:
//   ADDR       7-bit address acknowledged
//   MIN_PHASE  minimum SCL high/low time in clk cycles that is tracked
// Ports:
//   clk      in     50 MHz system clock
//   reset_n  in     asynchronous active-low reset
//   scl      in     bus clock from the controller
//   sda      inout  bus data, only ever pulled low or released
//   data_in  in     word served on reads, captured at the address ACK
//   wr_data  out    last byte received in a write
//   wr_valid out    one-clk strobe when wr_data updates
//   rd_done  out    one-clk strobe when the controller NACKs a read byte
//   busy     out    high from the address ACK until STOP or return to idle
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR      = I2C_DEFAULT_TARGET_ADDR,
  parameter int         MIN_PHASE = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scl,
  inout  wire               sda,
  input  logic [DATA_W-1:0] data_in,
  output logic [BYTE_W-1:0] wr_data,
  output logic              wr_valid,
  output logic              rd_done,
  output logic              busy
);

  // Phases shorter than the synchronizer path cannot be tracked at all; the
  // parameter itself drives no logic.
  if (MIN_PHASE < 4) begin : g_phase_below_sync_latency
  end

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .line_in (scl),
    .line    (scl_s),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .line_in (sda),
    .line    (sda_s),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  i2c_target_state_t  state;
  logic [BYTE_W-2:0]  shift_reg;
  logic [3:0]         bit_cnt;
  logic               rw;
  logic               ack_drv;
  logic               byte_hi;
  logic [DATA_W-1:0]  snapshot;
  logic               sda_low;

  logic               start_cond;
  logic               stop_cond;
  logic [BYTE_W-1:0]  next_byte;
  logic [BYTE_W-1:0]  cur_byte;

  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;
  assign next_byte  = {shift_reg, sda_s};
  assign cur_byte   = select_byte(snapshot, byte_hi);

  // Open-drain: the async reset of sda_low releases the line immediately.
  assign sda = sda_low ? 1'b0 : 1'bz;

  // Protocol FSM. START/STOP are checked first so they win over bit sampling.
  // Bits are sampled on scl rise and sda is changed only on scl fall. In the
  // two ACK states ack_drv tells the fall that starts the ACK clock (pull low)
  // from the fall that ends it (release and move on).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      rw        <= 1'b0;
      ack_drv   <= 1'b0;
      byte_hi   <= 1'b1;
      snapshot  <= '0;
      sda_low   <= 1'b0;
      wr_data   <= '0;
      wr_valid  <= 1'b0;
      rd_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      rd_done  <= 1'b0;
      if (start_cond) begin
        state   <= S_ADDR;
        bit_cnt <= '0;
        ack_drv <= 1'b0;
        sda_low <= 1'b0;
      end else if (stop_cond) begin
        state   <= S_IDLE;
        ack_drv <= 1'b0;
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise) begin
              shift_reg <= next_byte[BYTE_W-2:0];
              if (bit_cnt == 4'd7) begin
                if (next_byte[7:1] == ADDR) begin
                  state   <= S_ADDR_ACK;
                  rw      <= next_byte[0];
                  ack_drv <= 1'b0;
                end else begin
                  state <= S_WAIT_STOP;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                sda_low <= 1'b1;
                ack_drv <= 1'b1;
                busy    <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                if (rw) begin
                  // The first read bit goes out on this same fall.
                  snapshot <= data_in;
                  byte_hi  <= 1'b1;
                  sda_low  <= ~data_in[DATA_W-1];
                  bit_cnt  <= 4'd1;
                  state    <= S_RD_BYTE;
                end else begin
                  sda_low <= 1'b0;
                  bit_cnt <= '0;
                  state   <= S_WR_BYTE;
                end
              end
            end
          end

          S_RD_BYTE: begin
            // bit_cnt counts bits already placed on the bus for this byte.
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_low <= 1'b0;
                state   <= S_RD_ACK;
              end else begin
                sda_low <= ~cur_byte[3'd7 - bit_cnt[2:0]];
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          S_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                byte_hi <= ~byte_hi;
                bit_cnt <= '0;
                state   <= S_RD_BYTE;
              end else begin
                rd_done <= 1'b1;
                state   <= S_WAIT_STOP;
              end
            end
          end

          S_WR_BYTE: begin
            if (scl_rise) begin
              shift_reg <= next_byte[BYTE_W-2:0];
              if (bit_cnt == 4'd7) begin
                wr_data  <= next_byte;
                wr_valid <= 1'b1;
                ack_drv  <= 1'b0;
                state    <= S_WR_ACK;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          S_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                sda_low <= 1'b1;
                ack_drv <= 1'b1;
              end else begin
                sda_low <= 1'b0;
                ack_drv <= 1'b0;
                bit_cnt <= '0;
                state   <= S_WR_BYTE;
              end
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

endmodule
